// File: rtl/ram_rr_arbiter_if.sv
// Client/RAM-side signal bundle for ram_rr_arbiter.
// The arbiter takes the slave view; the client/RAM environment takes the master view.
interface ram_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  clear_start;
  logic                  busy;
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  clear_start, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output busy, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr, ram_din
  );

  modport master (
    output clear_start, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  busy, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin sharing of one single-port RAM between two requesters, with a
// zero-fill sweep after reset or on clear_start.
module ram_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  ram_rr_arbiter_if.slave bus
);
  typedef enum logic {CLEAR, ARB} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;
  logic                  ptr_reg, ptr_next;
  logic                  rvalid0_reg, rvalid1_reg;

  logic                  gnt0, gnt1, busy;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
      ptr_reg      <= 1'b0;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      ptr_reg      <= ptr_next;
      rvalid0_reg  <= gnt0 & ~bus.we0;
      rvalid1_reg  <= gnt1 & ~bus.we1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    ptr_next      = ptr_reg;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    busy          = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_din       = '0;
    case (state_reg)
      CLEAR: begin
        busy          = 1'b1;
        ram_we        = 1'b1;
        ram_addr      = clr_addr_reg;
        // Natural wrap leaves clr_addr at 0 for the next sweep.
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == {ADDR_WIDTH{1'b1}})
          state_next = ARB;
      end
      ARB: begin
        if (bus.clear_start) begin
          state_next = CLEAR;
        end else begin
          gnt0 = bus.req0 & (~bus.req1 | ~ptr_reg);
          gnt1 = bus.req1 & (~bus.req0 |  ptr_reg);
          if (gnt0) begin
            ram_we   = bus.we0;
            ram_addr = bus.addr0;
            ram_din  = bus.wdata0;
            ptr_next = 1'b1;
          end else if (gnt1) begin
            ram_we   = bus.we1;
            ram_addr = bus.addr1;
            ram_din  = bus.wdata1;
            ptr_next = 1'b0;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.ram_we   = ram_we;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_din  = ram_din;
  assign bus.rvalid0  = rvalid0_reg;
  assign bus.rvalid1  = rvalid1_reg;
  // The RAM output register already aligns with rvalid, so data passes straight through.
  assign bus.rdata0   = bus.ram_dout;
  assign bus.rdata1   = bus.ram_dout;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the arbiter and its attached RAM contents.
module tb_ram_rr_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Attached single-port RAM with a registered read port.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_dout_q;
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'($urandom);
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    ram_dout_q <= ram_mem[bus.ram_addr];
  end
  assign bus.ram_dout = ram_dout_q;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  bit            m_clearing;
  int            m_idx;
  int            m_last;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];
  bit            m_g  [2];

  task automatic set_idle();
    bus.clear_start = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic drive(input int i, input bit r, input bit w, input int a, input int d);
    if (i == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = AW'(a); bus.wdata0 = DW'(d);
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = AW'(a); bus.wdata1 = DW'(d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 1);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rvalid1", bus.rvalid1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_clearing = 1; m_idx = 0; m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_g[0] = 0; m_g[1] = 0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic step();
    bit            g0, g1, w;
    int            sel;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g0 = 0; g1 = 0; sel = -1; w = 0; a = '0; d = '0;
    @(negedge clk);
    check("busy", bus.busy, m_clearing);
    check("rvalid0", bus.rvalid0, m_rv[0]);
    check("rvalid1", bus.rvalid1, m_rv[1]);
    if (m_rv[0]) check("rdata0", bus.rdata0, m_rd[0]);
    if (m_rv[1]) check("rdata1", bus.rdata1, m_rd[1]);
    if (m_clearing) begin
      check("clr_we", bus.ram_we, 1);
      check("clr_addr", bus.ram_addr, m_idx);
      check("clr_din", bus.ram_din, 0);
    end else if (!bus.clear_start) begin
      g0 = bus.req0 && (!bus.req1 || m_last == 1);
      g1 = bus.req1 && (!bus.req0 || m_last == 0);
    end
    check("gnt0", bus.gnt0, g0);
    check("gnt1", bus.gnt1, g1);
    if (!m_clearing) begin
      if (g0) begin sel = 0; w = bus.we0; a = bus.addr0; d = bus.wdata0; end
      if (g1) begin sel = 1; w = bus.we1; a = bus.addr1; d = bus.wdata1; end
      check("ram_drive", {bus.ram_we, bus.ram_addr, bus.ram_din}, {w, a, d});
      if (sel >= 0)
        $display("t=%0t gnt%0d %s addr=%0d wdata=%02h", $time, sel, w ? "WR" : "RD", a, d);
    end
    m_rv[0] = 0; m_rv[1] = 0;
    if (m_clearing) begin
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) begin m_clearing = 0; m_idx = 0; end
    end else if (bus.clear_start) begin
      m_clearing = 1; m_idx = 0;
    end else if (sel >= 0) begin
      if (w) m_mem[a] = d;
      else begin m_rv[sel] = 1; m_rd[sel] = m_mem[a]; end
      m_last = sel;
    end
    m_g[0] = g0; m_g[1] = g1;
    @(posedge clk); #1;
  endtask

  initial begin
    set_idle();
    #2;
    do_reset();
    repeat (DEPTH) step();
    step();
    check("sweep_done_busy", bus.busy, 0);

    // Write then read back on requester 0
    drive(0, 1, 1, 3, 8'hA5); step();
    drive(0, 1, 0, 3, 0);     step();
    set_idle();               step();

    // Contended reads alternate
    drive(0, 1, 0, 1, 0); drive(1, 1, 0, 2, 0);
    repeat (4) step();
    set_idle(); step();

    // Cross-requester read-after-write
    drive(1, 1, 1, 7, 8'h3C); step();
    set_idle(); drive(0, 1, 0, 7, 0); step();
    set_idle(); step();

    // Clear wipes data; a request held during the sweep is served afterwards
    drive(0, 1, 1, 5, 8'hFF); step();
    set_idle(); bus.clear_start = 1'b1; step();
    bus.clear_start = 1'b0; drive(1, 1, 0, 5, 0);
    for (int n = 0; n < 40 && m_clearing; n++) step();
    check("clear_end_busy", bus.busy, 0);
    step();
    set_idle(); drive(0, 1, 0, 5, 0); step();
    set_idle(); step();

    // Reset right after a read grant drops the pending rvalid
    drive(0, 1, 0, 3, 0); step();
    set_idle();
    do_reset();
    repeat (9) step();
    do_reset();
    repeat (DEPTH) step();
    step();

    // Random traffic with held requests and occasional clears
    for (int c = 0; c < 600; c++) begin
      if (!(bus.req0 && !m_g[0]))
        drive(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom_range(0, 255));
      if (!(bus.req1 && !m_g[1]))
        drive(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom_range(0, 255));
      bus.clear_start = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
